// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM.
// m0 is the core load/store port and m1 is the debug/loader port.
// Contended cycles are resolved round-robin. m1 may lock the grant for
// back-to-back cycles, but only for a bounded number of cycles while m0 waits.
// Read data comes back one cycle after the grant and is routed to the master
// that issued the read.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                rstn,
    // m0: core load/store
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_wem_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    // m1: debug/loader
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_wem_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic                m1_lock_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    // slave: single-port RAM
    output logic                s_cs_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_wem_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    // hold request to the pipeline controller
    output logic                stall_o
);

    localparam int CNT_W = $clog2(MAX_LOCK) + 1;

    // This FSM records which master issued the read in the previous cycle.
    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1
    } state_t;

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;   // 1 = m1 was granted most recently
    logic               m1_prev_q, m1_prev_d;     // m1 held the grant last cycle
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic               m0_gnt;
    logic               m1_gnt;
    logic               lock_hold;
    logic               lock_expired;

    // Arbitration: locked m1 first, then round-robin. The grant is gated by
    // rstn so it stays low for the whole time reset is asserted.
    always_comb begin
        // NOTE: every signal written here gets a default value first. If one
        // branch did not assign a signal, synthesis would build a latch for it.
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        lock_expired = m0_req_i && (lock_cnt_q >= CNT_W'(MAX_LOCK));
        lock_hold    = m1_prev_q && m1_req_i && m1_lock_i && !lock_expired;
        if (rstn) begin
            if (lock_hold) begin
                m1_gnt = 1'b1;
            end else if (m0_req_i && m1_req_i) begin
                m0_gnt = last_gnt_q;
                m1_gnt = !last_gnt_q;
            end else begin
                m0_gnt = m0_req_i;
                m1_gnt = m1_req_i;
            end
        end
    end

    assign m0_gnt_o = m0_gnt;
    assign m1_gnt_o = m1_gnt;
    assign stall_o  = rstn && m0_req_i && !m0_gnt;

    // Slave port mux: drives the winner's signals, or all zeros when nobody holds the grant.
    always_comb begin
        s_cs_o    = 1'b0;
        s_we_o    = 1'b0;
        s_wem_o   = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (m0_gnt) begin
            s_cs_o    = 1'b1;
            s_we_o    = m0_we_i;
            s_wem_o   = m0_wem_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
        end else if (m1_gnt) begin
            s_cs_o    = 1'b1;
            s_we_o    = m1_we_i;
            s_wem_o   = m1_wem_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end
    end

    // Next-state logic for the read-owner FSM, the round-robin pointer and the lock counter.
    always_comb begin
        state_d    = IDLE;
        last_gnt_d = last_gnt_q;
        m1_prev_d  = m1_gnt;
        lock_cnt_d = '0;
        if (m0_gnt) begin
            last_gnt_d = 1'b0;
            if (!m0_we_i) state_d = RD0;
        end else if (m1_gnt) begin
            last_gnt_d = 1'b1;
            if (!m1_we_i) state_d = RD1;
        end
        if (lock_hold && m0_req_i) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
    end

    // State registers. Asynchronous reset clears them, which drops any read still pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            m1_prev_q  <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop take the value
            // from before the clock edge, so the order of these lines does not matter.
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            m1_prev_q  <= m1_prev_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Response routing: the RAM data goes to the owner of last cycle's read.
    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        if (state_q == RD0) begin
            m0_rvalid_o = 1'b1;
            m0_rdata_o  = s_rdata_i;
        end else if (state_q == RD1) begin
            m1_rvalid_o = 1'b1;
            m1_rdata_o  = s_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. The bench drives inputs 1 ns after the
// rising edge, checks outputs on the falling edge, and models the RAM itself.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              m0_req_i, m0_we_i;
    logic [3:0]        m0_wem_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_gnt_o, m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m1_req_i, m1_we_i, m1_lock_i;
    logic [3:0]        m1_wem_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_gnt_o, m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              s_cs_o, s_we_o;
    logic [3:0]        s_wem_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic [DATA_W-1:0] s_rdata_i = '0;
    logic              stall_o;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [16];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_wem_i(m0_wem_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_wem_i(m1_wem_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_cs_o(s_cs_o), .s_we_o(s_we_o), .s_wem_o(s_wem_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .stall_o(stall_o)
    );

    // RAM model: 16 words with byte-masked writes and a one-cycle read latency.
    always @(posedge clk) begin
        if (s_cs_o) begin
            if (s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (s_wem_o[b]) mem[s_addr_o[5:2]][b*8 +: 8] <= s_wdata_o[b*8 +: 8];
            end else begin
                s_rdata_i <= mem[s_addr_o[5:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr);
        m0_req_i = req; m0_we_i = we; m0_addr_i = addr;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [3:0] wem,
                          input logic [31:0] addr, input logic lock);
        m1_req_i = req; m1_we_i = we; m1_wem_i = wem; m1_addr_i = addr; m1_lock_i = lock;
    endtask

    // Advance to the falling edge, where outputs are sampled.
    task automatic to_sample();
        @(negedge clk);
    endtask

    // Advance to 1 ns after the next rising edge, where inputs are driven.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h1234_5678;
        mem[2] = 32'h2222_2222;
        mem[4] = 32'hDEAD_BEEF;
        m0_wem_i = 4'hF; m0_wdata_i = 32'h0;
        m1_wdata_i = 32'hA5A5_A5A5;
        drive0(1'b1, 1'b0, 32'h0);
        drive1(1'b1, 1'b0, 4'h0, 32'h8, 1'b0);
        rstn = 1'b0;

        // Reset: outputs forced low even with requests pending.
        to_sample();
        check("rst_m0_gnt", m0_gnt_o, 0);
        check("rst_m1_gnt", m1_gnt_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_cs", s_cs_o, 0);
        check("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
        to_drive();
        to_drive();
        rstn = 1'b1;

        // Contention for four cycles: m0, m1, m0, m1.
        to_sample();
        check("c1_gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
        check("c1_stall", stall_o, 0);
        check("c1_addr", s_addr_o, 32'h0);
        to_drive();
        to_sample();
        check("c2_gnt", {m0_gnt_o, m1_gnt_o}, 2'b01);
        check("c2_stall", stall_o, 1);
        check("c2_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b10);
        check("c2_rdata", m0_rdata_o, 32'h1111_1111);
        to_drive();
        to_sample();
        check("c3_gnt", {m0_gnt_o, m1_gnt_o}, 2'b10);
        check("c3_stall", stall_o, 0);
        check("c3_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b01);
        check("c3_rdata", m1_rdata_o, 32'h2222_2222);
        to_drive();
        to_sample();
        check("c4_gnt", {m0_gnt_o, m1_gnt_o}, 2'b01);
        check("c4_stall", stall_o, 1);
        to_drive();
        drive0(1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        to_sample();
        check("idle_cs", s_cs_o, 0);
        check("idle_addr", s_addr_o, 0);
        check("c5_m1_rvalid", m1_rvalid_o, 1);
        to_drive();

        // Single read: m0 reads 0x10.
        drive0(1'b1, 1'b0, 32'h10);
        to_sample();
        check("sr_gnt", m0_gnt_o, 1);
        check("sr_addr", s_addr_o, 32'h10);
        to_drive();
        drive0(1'b0, 1'b0, 32'h0);
        to_sample();
        check("sr_rvalid", m0_rvalid_o, 1);
        check("sr_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("sr_m1_out", {m1_rvalid_o, m1_rdata_o}, 0);
        to_drive();
        to_sample();
        check("sr_one_shot", m0_rvalid_o, 0);
        to_drive();

        // Back-to-back mixed traffic: m0 read 0x0, m1 write 0x4, m1 read 0x8.
        drive0(1'b1, 1'b0, 32'h0);
        to_sample();
        check("bb0_gnt", m0_gnt_o, 1);
        to_drive();
        drive0(1'b0, 1'b0, 32'h0);
        drive1(1'b1, 1'b1, 4'b0011, 32'h4, 1'b0);
        to_sample();
        check("bb1_m1_gnt", m1_gnt_o, 1);
        check("bb1_we_wem", {s_we_o, s_wem_o}, 5'b1_0011);
        check("bb1_m0_rvalid", m0_rvalid_o, 1);
        check("bb1_m0_rdata", m0_rdata_o, 32'h1111_1111);
        to_drive();
        drive1(1'b1, 1'b0, 4'h0, 32'h8, 1'b0);
        to_sample();
        check("bb2_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
        to_drive();
        drive1(1'b1, 1'b0, 4'h0, 32'h4, 1'b0);
        to_sample();
        check("bb3_m1_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b01);
        check("bb3_m1_rdata", m1_rdata_o, 32'h2222_2222);
        to_drive();
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        to_sample();
        check("bb4_masked_write", m1_rdata_o, 32'h1234_A5A5);
        to_drive();

        // Lock starvation: m1 takes the grant alone, then holds it locked
        // while m0 requests from cycle 0.
        drive1(1'b1, 1'b0, 4'h0, 32'h8, 1'b1);
        to_sample();
        check("lk_pre_gnt", m1_gnt_o, 1);
        to_drive();
        drive0(1'b1, 1'b0, 32'h10);
        for (int i = 0; i <= 8; i++) begin
            to_sample();
            check($sformatf("lk%0d_m1_gnt", i), m1_gnt_o, (i < 8) ? 1 : 0);
            check($sformatf("lk%0d_m0_gnt", i), m0_gnt_o, (i == 8) ? 1 : 0);
            check($sformatf("lk%0d_stall", i), stall_o, (i < 8) ? 1 : 0);
            to_drive();
        end
        drive0(1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        to_drive();

        // Reset asserted while an m0 read is pending.
        drive0(1'b1, 1'b0, 32'h10);
        to_sample();
        check("rr_gnt", m0_gnt_o, 1);
        to_drive();
        drive0(1'b0, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        check("rr_rvalid_now", m0_rvalid_o, 0);
        check("rr_rdata_now", m0_rdata_o, 0);
        to_drive();
        rstn = 1'b1;
        to_sample();
        check("rr_rvalid_after", {m0_rvalid_o, m1_rvalid_o}, 0);
        to_drive();
        drive0(1'b1, 1'b0, 32'h10);
        to_sample();
        check("rr_first_gnt", m0_gnt_o, 1);
        check("rr_first_stall", stall_o, 0);
        to_drive();
        drive0(1'b0, 1'b0, 32'h0);
        to_sample();
        check("rr_new_rdata", m0_rdata_o, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_LOCK, default 8, meaning the maximum number of consecutive cycles m1 may hold a locked grant while m0 requests.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have m0 (core load/store) ports: m0_req_i in 1; m0_we_i in 1; m0_wem_i in DATA_W/8; m0_addr_i in ADDR_W; m0_wdata_i in DATA_W; m0_gnt_o out 1; m0_rvalid_o out 1; m0_rdata_o out DATA_W.
REQ-007 SHALL have m1 (debug/loader) ports identical to m0 with prefix m1_, plus m1_lock_i in 1, which requests that the grant be held across consecutive cycles.
REQ-008 SHALL have slave (single-port RAM) ports: s_cs_o out 1; s_we_o out 1; s_wem_o out DATA_W/8; s_addr_o out ADDR_W; s_wdata_o out DATA_W; s_rdata_i in DATA_W, valid one cycle after the read access.
REQ-009 SHALL have port stall_o, output, 1, a request to the pipeline controller to hold the core while m0 is refused.

Function
REQ-010 SHALL decide the grant combinationally in the request cycle; at most one of m0_gnt_o and m1_gnt_o is high.
REQ-011 SHALL assert mX_gnt_o only while mX_req_i is high.
- Single requester: granted immediately.
REQ-012 SHALL resolve two requesters round-robin: the master not granted most recently wins; register last_gnt is updated on every grant cycle.
REQ-013 SHALL reset last_gnt to m1, so m0 wins the first contended cycle.
REQ-014 SHALL drive the slave ports from the winner's signals when any grant is high (s_cs_o=1).
- No grant: s_cs_o=0, s_we_o=0, s_wem_o=0, s_addr_o=0, s_wdata_o=0.
REQ-015 SHALL implement an owner FSM with states IDLE, RD0 and RD1, holding the owner of the read issued in the previous cycle.
- Next state is RD0/RD1 on a granted read (we=0) by m0/m1; IDLE otherwise (write or no grant).
REQ-016 SHALL assert mX_rvalid_o for exactly one cycle while in RDX, with mX_rdata_o=s_rdata_i; otherwise mX_rvalid_o=0 and mX_rdata_o=0.
- Read latency: grant cycle+1.
- Writes produce no rvalid.
REQ-017 SHALL support back-to-back reads: a read granted in cycle N+1 does not suppress the rvalid for the read of cycle N.
- Alternating owners route each response to its own master.
REQ-018 SHALL hold the m1 grant, when m1 was granted last cycle and m1_req_i and m1_lock_i are both high, regardless of m0 and round-robin.
REQ-019 SHALL count locked cycles in lock_cnt (width clog2(MAX_LOCK)+1).
- Increments on each locked cycle while m0_req_i=1.
- Clears when the lock drops, on any m0 grant, or when m0_req_i=0.
REQ-020 SHALL force-release the lock when lock_cnt reaches MAX_LOCK while m0_req_i=1: m0 is granted the next cycle and lock_cnt clears.
REQ-021 SHALL drive stall_o=m0_req_i & ~m0_gnt_o (combinational).
REQ-022 SHALL permit no combinational path from s_rdata_i to any gnt output or to stall_o.

Reset
REQ-023 SHALL, while rstn=0 (asynchronous), set FSM=IDLE, last_gnt=m1 and lock_cnt=0, force both gnt outputs and both rvalid outputs to 0, all rdata to 0, s_cs_o=0 and stall_o=0.
REQ-024 SHALL drop a read pending at reset assertion: no rvalid occurs after rstn deasserts.
REQ-025 SHALL grant the first cycle after reset release normally, with no extra wait state.

Verification
REQ-026 SHALL pass the single read case: m0 reads addr 0x10, RAM holds 0xDEADBEEF -> m0_gnt_o=1 in cycle N, m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in N+1, m1 outputs 0.
REQ-027 SHALL pass the contention case: m0 and m1 request every cycle for 4 cycles after reset -> grants m0,m1,m0,m1; stall_o=1 in cycles 2 and 4.
REQ-028 SHALL pass the lock starvation case: MAX_LOCK=8, m1 locked reads continuously, m0 requests from cycle 0 -> m1 granted cycles 0-7, m0 granted cycle 8, stall_o=1 cycles 0-7.
REQ-029 SHALL pass the back-to-back mixed case: m0 read 0x0 in cycle N, m1 write 0x4 with wem=4'b0011 in N+1, m1 read 0x8 in N+2 -> m0_rvalid_o in N+1, no rvalid in N+2, m1_rvalid_o in N+3, s_wem_o=4'b0011 in N+1.
REQ-030 SHALL pass the reset mid-read case: rstn low in the cycle after an m0 read grant -> m0_rvalid_o=0 immediately and stays 0 after release; next m0 request is granted in its first cycle.
